// File: rtl/cpu_consts.sv
// Shared constants and types for the issue stage and execute interface.
package cpu_consts;

    localparam int EXU_FUNC_W = 4;

    typedef enum logic [1:0] {
        CLS_ALU = 2'd0,
        CLS_MUL = 2'd1,
        CLS_DIV = 2'd2,
        CLS_ILL = 2'd3
    } exu_class_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_LONG = 2'd2
    } issue_state_t;

    function automatic logic is_long(input exu_class_t cls);
        return (cls == CLS_MUL) || (cls == CLS_DIV);
    endfunction

endpackage

// File: rtl/exu_issue_wb_reg.sv
// Writeback capture register: one-cycle valid with the captured rd, data and write enable.
module exu_issue_wb_reg #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cap,
    input  logic            we_en,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] data,
    output logic            wb_valid,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data
);

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= cap;
            wb_we    <= cap && we_en;
            if (cap) begin
                wb_rd   <= rd;
                wb_data <= data;
            end
        end
    end

endmodule

// File: rtl/exu_issue.sv
// Issue stage feeding the execute unit: operand hold for mul/div, writeback capture,
// flush/kill handling and a watchdog on long operations.
//
// state      | meaning
// IDLE       | no operation held
// ISSUE      | ALU op, or first cycle of a MUL/DIV op, presented to execute
// WAIT_LONG  | MUL/DIV in flight, operands held, watchdog counting
module exu_issue
    import cpu_consts::*;
#(
    parameter int XLEN    = 64,
    parameter int FUNC_W  = EXU_FUNC_W,
    parameter int MAX_LAT = 80
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid_i,
    output logic              dec_ready_o,
    input  logic [XLEN-1:0]   dec_opr_a_i,
    input  logic [XLEN-1:0]   dec_opr_b_i,
    input  logic [FUNC_W-1:0] dec_func_i,
    input  logic              dec_word_op_i,
    input  logic [1:0]        dec_class_i,
    input  logic [4:0]        dec_rd_i,
    input  logic              flush_i,
    input  logic              kill_i,
    output logic [XLEN-1:0]   opr_a_o,
    output logic [XLEN-1:0]   opr_b_o,
    output logic [FUNC_W-1:0] exu_func_o,
    output logic              word_op_o,
    output logic              mul_instr_o,
    output logic              div_instr_o,
    output logic              flush_o,
    output logic              kill_o,
    input  logic [XLEN-1:0]   exu_res_i,
    input  logic              valid_res_i,
    input  logic              exu_busy_i,
    output logic              wb_valid_o,
    output logic              wb_we_o,
    output logic [4:0]        wb_rd_o,
    output logic [XLEN-1:0]   wb_data_o,
    output logic [4:0]        busy_rd_o,
    output logic              busy_rd_valid_o,
    output logic              timeout_o
);

    localparam int CNT_W = $clog2(MAX_LAT + 1);

    issue_state_t     state;
    exu_class_t       cls_q;
    exu_class_t       dec_cls;
    logic [4:0]       rd_q;
    logic [CNT_W-1:0] wd_cnt;

    logic abort;
    logic accept;
    logic wd_fire;
    logic wb_cap;
    logic wb_we_en;

    // Completion is signalled only by valid_res_i; the busy flag is not used.
    logic unused_busy;
    assign unused_busy = exu_busy_i;

    assign dec_cls = exu_class_t'(dec_class_i);
    assign abort   = flush_i || kill_i;

    assign dec_ready_o = !reset && !abort &&
                         ((state == ST_IDLE) || (state == ST_ISSUE && cls_q == CLS_ALU));
    assign accept      = dec_valid_i && dec_ready_o;

    assign wd_fire = (state == ST_WAIT_LONG) && !abort && !valid_res_i &&
                     (wd_cnt == CNT_W'(MAX_LAT - 1));

    // ALU results arrive combinationally in ISSUE; illegal ops retire as no-ops there too.
    assign wb_cap   = !abort &&
                      ((state == ST_ISSUE && (cls_q == CLS_ALU || cls_q == CLS_ILL)) ||
                       (state == ST_WAIT_LONG && valid_res_i));
    assign wb_we_en = (cls_q != CLS_ILL) && (rd_q != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            cls_q           <= CLS_ALU;
            rd_q            <= '0;
            wd_cnt          <= '0;
            opr_a_o         <= '0;
            opr_b_o         <= '0;
            exu_func_o      <= '0;
            word_op_o       <= 1'b0;
            mul_instr_o     <= 1'b0;
            div_instr_o     <= 1'b0;
            flush_o         <= 1'b0;
            kill_o          <= 1'b0;
            busy_rd_o       <= '0;
            busy_rd_valid_o <= 1'b0;
            timeout_o       <= 1'b0;
        end else begin
            mul_instr_o <= 1'b0;
            div_instr_o <= 1'b0;
            timeout_o   <= 1'b0;
            flush_o     <= flush_i;
            kill_o      <= kill_i || wd_fire;

            if (accept) begin
                state           <= ST_ISSUE;
                cls_q           <= dec_cls;
                rd_q            <= dec_rd_i;
                wd_cnt          <= '0;
                opr_a_o         <= dec_opr_a_i;
                opr_b_o         <= dec_opr_b_i;
                exu_func_o      <= dec_func_i;
                word_op_o       <= dec_word_op_i;
                mul_instr_o     <= (dec_cls == CLS_MUL);
                div_instr_o     <= (dec_cls == CLS_DIV);
                busy_rd_valid_o <= is_long(dec_cls);
                if (is_long(dec_cls)) begin
                    busy_rd_o <= dec_rd_i;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        wd_cnt <= '0;
                    end
                    ST_ISSUE: begin
                        wd_cnt <= '0;
                        if (!abort && is_long(cls_q)) begin
                            state <= ST_WAIT_LONG;
                        end else begin
                            state           <= ST_IDLE;
                            busy_rd_valid_o <= 1'b0;
                        end
                    end
                    ST_WAIT_LONG: begin
                        if (abort || valid_res_i || wd_fire) begin
                            state           <= ST_IDLE;
                            wd_cnt          <= '0;
                            busy_rd_valid_o <= 1'b0;
                            timeout_o       <= wd_fire;
                        end else begin
                            wd_cnt <= wd_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        wd_cnt <= '0;
                    end
                endcase
            end
        end
    end

    exu_issue_wb_reg #(.XLEN(XLEN)) u_wb_reg (
        .clk      (clk),
        .reset    (reset),
        .cap      (wb_cap),
        .we_en    (wb_we_en),
        .rd       (rd_q),
        .data     (exu_res_i),
        .wb_valid (wb_valid_o),
        .wb_we    (wb_we_o),
        .wb_rd    (wb_rd_o),
        .wb_data  (wb_data_o)
    );

endmodule

// File: tb/tb_exu_issue.sv
// Directed testbench for exu_issue with hand-computed expected values.
module tb_exu_issue;

    localparam int XLEN    = 64;
    localparam int FUNC_W  = 4;
    localparam int MAX_LAT = 80;

    logic              clk = 1'b0;
    logic              reset;
    logic              dec_valid_i;
    logic              dec_ready_o;
    logic [XLEN-1:0]   dec_opr_a_i;
    logic [XLEN-1:0]   dec_opr_b_i;
    logic [FUNC_W-1:0] dec_func_i;
    logic              dec_word_op_i;
    logic [1:0]        dec_class_i;
    logic [4:0]        dec_rd_i;
    logic              flush_i;
    logic              kill_i;
    logic [XLEN-1:0]   opr_a_o;
    logic [XLEN-1:0]   opr_b_o;
    logic [FUNC_W-1:0] exu_func_o;
    logic              word_op_o;
    logic              mul_instr_o;
    logic              div_instr_o;
    logic              flush_o;
    logic              kill_o;
    logic [XLEN-1:0]   exu_res_i;
    logic              valid_res_i;
    logic              exu_busy_i;
    logic              wb_valid_o;
    logic              wb_we_o;
    logic [4:0]        wb_rd_o;
    logic [XLEN-1:0]   wb_data_o;
    logic [4:0]        busy_rd_o;
    logic              busy_rd_valid_o;
    logic              timeout_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    exu_issue #(.XLEN(XLEN), .FUNC_W(FUNC_W), .MAX_LAT(MAX_LAT)) dut (
        .clk             (clk),
        .reset           (reset),
        .dec_valid_i     (dec_valid_i),
        .dec_ready_o     (dec_ready_o),
        .dec_opr_a_i     (dec_opr_a_i),
        .dec_opr_b_i     (dec_opr_b_i),
        .dec_func_i      (dec_func_i),
        .dec_word_op_i   (dec_word_op_i),
        .dec_class_i     (dec_class_i),
        .dec_rd_i        (dec_rd_i),
        .flush_i         (flush_i),
        .kill_i          (kill_i),
        .opr_a_o         (opr_a_o),
        .opr_b_o         (opr_b_o),
        .exu_func_o      (exu_func_o),
        .word_op_o       (word_op_o),
        .mul_instr_o     (mul_instr_o),
        .div_instr_o     (div_instr_o),
        .flush_o         (flush_o),
        .kill_o          (kill_o),
        .exu_res_i       (exu_res_i),
        .valid_res_i     (valid_res_i),
        .exu_busy_i      (exu_busy_i),
        .wb_valid_o      (wb_valid_o),
        .wb_we_o         (wb_we_o),
        .wb_rd_o         (wb_rd_o),
        .wb_data_o       (wb_data_o),
        .busy_rd_o       (busy_rd_o),
        .busy_rd_valid_o (busy_rd_valid_o),
        .timeout_o       (timeout_o)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic v, input logic [1:0] cls, input logic [4:0] rd,
                            input logic [63:0] a, input logic [63:0] b);
        dec_valid_i   = v;
        dec_class_i   = cls;
        dec_rd_i      = rd;
        dec_opr_a_i   = a;
        dec_opr_b_i   = b;
        dec_func_i    = 4'h3;
        dec_word_op_i = 1'b0;
    endtask

    task automatic idle_inputs();
        drive_op(1'b0, 2'd0, 5'd0, 64'd0, 64'd0);
        flush_i     = 1'b0;
        kill_i      = 1'b0;
        valid_res_i = 1'b0;
        exu_res_i   = '0;
        exu_busy_i  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int ready_low;
        int mul_pulses;
        int wb_seen;
        int wd_at;

        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        check_val("rst_ready",   64'(dec_ready_o),     64'd0);
        check_val("rst_wbvalid", 64'(wb_valid_o),      64'd0);
        check_val("rst_opra",    opr_a_o,              64'd0);
        check_val("rst_busyv",   64'(busy_rd_valid_o), 64'd0);
        check_val("rst_timeout", 64'(timeout_o),       64'd0);
        reset = 1'b0;
        #1;
        check_val("idle_ready", 64'(dec_ready_o), 64'd1);

        // ALU back-to-back, rd 1,2,3
        tick();
        drive_op(1'b1, 2'd0, 5'd1, 64'hA1, 64'hB1);
        #1;
        check_val("alu_c0_ready", 64'(dec_ready_o), 64'd1);
        tick();
        drive_op(1'b1, 2'd0, 5'd2, 64'hA2, 64'hB2);
        valid_res_i = 1'b1;
        exu_res_i   = 64'h11;
        #1;
        check_val("alu_c1_opra",  opr_a_o,            64'hA1);
        check_val("alu_c1_ready", 64'(dec_ready_o),   64'd1);
        check_val("alu_c1_wbv",   64'(wb_valid_o),    64'd0);
        tick();
        drive_op(1'b1, 2'd0, 5'd3, 64'hA3, 64'hB3);
        exu_res_i = 64'h22;
        #1;
        check_val("alu_c2_wbv",  64'(wb_valid_o), 64'd1);
        check_val("alu_c2_rd",   64'(wb_rd_o),    64'd1);
        check_val("alu_c2_data", wb_data_o,       64'h11);
        check_val("alu_c2_we",   64'(wb_we_o),    64'd1);
        tick();
        drive_op(1'b0, 2'd0, 5'd0, 64'd0, 64'd0);
        exu_res_i = 64'h33;
        #1;
        check_val("alu_c3_rd",   64'(wb_rd_o), 64'd2);
        check_val("alu_c3_data", wb_data_o,    64'h22);
        tick();
        valid_res_i = 1'b0;
        #1;
        check_val("alu_c4_wbv",  64'(wb_valid_o), 64'd1);
        check_val("alu_c4_rd",   64'(wb_rd_o),    64'd3);
        check_val("alu_c4_data", wb_data_o,       64'h33);
        tick();
        check_val("alu_c5_wbv", 64'(wb_valid_o), 64'd0);

        // rd = 0 ALU op: valid writeback without write enable
        drive_op(1'b1, 2'd0, 5'd0, 64'h5, 64'h5);
        tick();
        drive_op(1'b0, 2'd0, 5'd0, 64'd0, 64'd0);
        valid_res_i = 1'b1;
        exu_res_i   = 64'h55;
        tick();
        valid_res_i = 1'b0;
        #1;
        check_val("rd0_wbv",  64'(wb_valid_o), 64'd1);
        check_val("rd0_we",   64'(wb_we_o),    64'd0);
        check_val("rd0_data", wb_data_o,       64'h55);

        // Illegal class retires as a no-op
        tick();
        drive_op(1'b1, 2'd3, 5'd7, 64'h7, 64'h7);
        tick();
        drive_op(1'b0, 2'd0, 5'd0, 64'd0, 64'd0);
        #1;
        check_val("ill_issue_ready", 64'(dec_ready_o), 64'd0);
        tick();
        check_val("ill_wbv", 64'(wb_valid_o), 64'd1);
        check_val("ill_we",  64'(wb_we_o),    64'd0);
        check_val("ill_rd",  64'(wb_rd_o),    64'd7);

        // MUL rd=5, result 4 cycles after the strobe
        tick();
        drive_op(1'b1, 2'd1, 5'd5, 64'hAAAA, 64'hBBBB);
        tick();
        drive_op(1'b0, 2'd0, 5'd0, 64'd0, 64'd0);
        #1;
        check_val("mul_busy_rd", 64'(busy_rd_o),       64'd5);
        check_val("mul_busy_v",  64'(busy_rd_valid_o), 64'd1);
        ready_low  = 0;
        mul_pulses = 0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) tick();
            valid_res_i = (k == 5);
            exu_res_i   = (k == 5) ? 64'h1234 : 64'd0;
            exu_busy_i  = (k >= 2 && k <= 5);
            #1;
            if (!dec_ready_o) ready_low++;
            if (mul_instr_o) mul_pulses++;
            if (k == 3) check_val("mul_hold_opra", opr_a_o, 64'hAAAA);
        end
        check_val("mul_ready_low", 64'(ready_low),       64'd5);
        check_val("mul_pulses",    64'(mul_pulses),      64'd1);
        check_val("mul_wbv",       64'(wb_valid_o),      64'd1);
        check_val("mul_rd",        64'(wb_rd_o),         64'd5);
        check_val("mul_data",      wb_data_o,            64'h1234);
        check_val("mul_busy_clr",  64'(busy_rd_valid_o), 64'd0);
        idle_inputs();

        // Flush two cycles after the divide strobe
        tick();
        drive_op(1'b1, 2'd2, 5'd9, 64'h90, 64'h3);
        tick();
        drive_op(1'b0, 2'd0, 5'd0, 64'd0, 64'd0);
        #1;
        check_val("div_strobe", 64'(div_instr_o), 64'd1);
        wb_seen = 0;
        tick();
        tick();
        flush_i = 1'b1;
        #1;
        check_val("div_flush_ready", 64'(dec_ready_o), 64'd0);
        tick();
        flush_i = 1'b0;
        #1;
        if (wb_valid_o) wb_seen++;
        check_val("div_after_ready", 64'(dec_ready_o),     64'd1);
        check_val("div_flush_o",     64'(flush_o),         64'd1);
        check_val("div_busy_clr",    64'(busy_rd_valid_o), 64'd0);
        tick();
        valid_res_i = 1'b1;
        exu_res_i   = 64'hDEAD;
        #1;
        if (wb_valid_o) wb_seen++;
        tick();
        valid_res_i = 1'b0;
        #1;
        if (wb_valid_o) wb_seen++;
        check_val("div_no_wb", 64'(wb_seen), 64'd0);

        // Watchdog: MUL with no result
        tick();
        drive_op(1'b1, 2'd1, 5'd4, 64'h4, 64'h4);
        wd_at   = -1;
        wb_seen = 0;
        for (int k = 1; k <= 200; k++) begin
            tick();
            drive_op(1'b0, 2'd0, 5'd0, 64'd0, 64'd0);
            #1;
            if (wb_valid_o) wb_seen++;
            if (timeout_o) begin
                wd_at = k;
                check_val("wd_kill",  64'(kill_o),      64'd1);
                check_val("wd_ready", 64'(dec_ready_o), 64'd1);
                break;
            end
        end
        check_val("wd_cycle", 64'(wd_at),   64'(MAX_LAT + 2));
        check_val("wd_no_wb", 64'(wb_seen), 64'd0);
        tick();
        check_val("wd_pulse_end", 64'({timeout_o, kill_o}), 64'd0);

        // Reset during WAIT_LONG, then an ALU op completes normally
        drive_op(1'b1, 2'd1, 5'd6, 64'h66, 64'h6);
        tick();
        drive_op(1'b0, 2'd0, 5'd0, 64'd0, 64'd0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_val("rstw_busyv", 64'(busy_rd_valid_o), 64'd0);
        check_val("rstw_busyrd", 64'(busy_rd_o),      64'd0);
        check_val("rstw_opra",  opr_a_o,              64'd0);
        check_val("rstw_ready", 64'(dec_ready_o),     64'd1);
        drive_op(1'b1, 2'd0, 5'd12, 64'hC, 64'hC);
        tick();
        drive_op(1'b0, 2'd0, 5'd0, 64'd0, 64'd0);
        valid_res_i = 1'b1;
        exu_res_i   = 64'h18;
        tick();
        valid_res_i = 1'b0;
        #1;
        check_val("rstw_alu_wbv",  64'(wb_valid_o), 64'd1);
        check_val("rstw_alu_rd",   64'(wb_rd_o),    64'd12);
        check_val("rstw_alu_data", wb_data_o,       64'h18);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/exu_issue.md
Name: exu_issue

Overview:
Issue stage directly upstream of the execute unit.
- Accepts one decoded operation per handshake from decode and registers its operands and function code.
- Drives the execute unit's operand, function, word-op and mul/div strobe inputs, and holds them stable while a long-latency multiply or divide is in flight.
- Captures the execute result together with the destination register and presents a registered writeback packet.
- Applies flush/kill and runs a watchdog on long operations.

Parameters:
- XLEN, 64, operand and result width.
- FUNC_W, 4, width of the exu function code (EXU_FUNC_W in cpu_consts).
- MAX_LAT, 80, maximum cycles allowed in WAIT_LONG before a timeout error.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- dec_valid_i  in  1  decode presents an operation
- dec_ready_o  out  1  issue can accept the operation this cycle
- dec_opr_a_i  in  XLEN  operand A
- dec_opr_b_i  in  XLEN  operand B
- dec_func_i  in  FUNC_W  function code
- dec_word_op_i  in  1  32-bit word operation
- dec_class_i  in  2  operation class: exu_class_t ALU=0, MUL=1, DIV=2; value 3 is illegal
- dec_rd_i  in  5  destination register
- flush_i  in  1  pipeline flush
- kill_i  in  1  kill the in-flight operation
- opr_a_o  out  XLEN  to execute
- opr_b_o  out  XLEN  to execute
- exu_func_o  out  FUNC_W  to execute
- word_op_o  out  1  to execute
- mul_instr_o  out  1  one-cycle multiply start strobe
- div_instr_o  out  1  one-cycle divide start strobe
- flush_o  out  1  flush_i forwarded to execute
- kill_o  out  1  kill_i forwarded to execute
- exu_res_i  in  XLEN  execute result
- valid_res_i  in  1  execute result valid
- exu_busy_i  in  1  mul/div unit busy
- wb_valid_o  out  1  writeback packet valid
- wb_we_o  out  1  register-file write enable (wb_valid_o and rd != 0)
- wb_rd_o  out  5  writeback destination register
- wb_data_o  out  XLEN  writeback data
- busy_rd_o  out  5  rd of the in-flight long operation, for the hazard check
- busy_rd_valid_o  out  1  busy_rd_o is meaningful
- timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset: all outputs 0; state IDLE; watchdog counter 0.
- States:
  - IDLE: no operation held.
  - ISSUE: ALU operation, or first cycle of a MUL/DIV operation, presented to execute.
  - WAIT_LONG: MUL/DIV in flight.
- dec_ready_o = (state == IDLE) or (state == ISSUE and the held class is ALU). This gives back-to-back ALU throughput of 1 per cycle.
- Accept occurs when dec_valid_i and dec_ready_o are both high. On accept, operands, func, word_op, rd and class are registered; next state is ISSUE.
- ISSUE with ALU class:
  - execute responds combinationally with valid_res_i in the same cycle.
  - exu_res_i is captured into the wb registers; wb_valid_o is high for one cycle, the cycle after ISSUE.
  - Latency from accept to wb_valid_o is 2 cycles.
  - Next state is ISSUE if another operation is accepted, else IDLE.
- ISSUE with MUL or DIV class:
  - mul_instr_o or div_instr_o is high for exactly that cycle.
  - busy_rd_valid_o goes high; next state is WAIT_LONG.
- WAIT_LONG:
  - Operand, func and word_op outputs stay held.
  - The watchdog counter increments each cycle.
  - On valid_res_i: capture the result with the saved rd; wb_valid_o is high the next cycle; clear busy_rd_valid_o and the counter; go to IDLE.
  - exu_busy_i is informational only; completion is signalled solely by valid_res_i.
- Watchdog: when the counter reaches MAX_LAT, pulse timeout_o and kill_o for one cycle, drop the operation (no wb_valid_o), and go to IDLE.
- flush_i or kill_i in any state:
  - The held operation is discarded and no wb_valid_o results from it.
  - Same-cycle accept is suppressed (dec_ready_o forced 0).
  - State goes to IDLE and the counter clears; a wb_valid_o already registered for an older op still completes.
- valid_res_i in IDLE is ignored.
- Class 3 is accepted and retired as a no-op: wb_valid_o=1, wb_we_o=0.
- A reset during WAIT_LONG behaves exactly like the reset values above.

Decomposition:
- cpu_consts holds exu_class_t (ALU, MUL, DIV, ILL), the issue state enum, and EXU_FUNC_W.
- One sub-module: exu_issue_wb_reg, the writeback capture register with valid, rd, data and we.

Test Plan:
- ALU back-to-back: three accepts in consecutive cycles, rd=1,2,3, with valid_res_i tied to ISSUE -> wb_valid_o on 3 consecutive cycles, starting 2 cycles after the first accept, rd 1,2,3 in order.
- MUL latency: accept MUL rd=5; execute returns valid_res_i after 4 cycles with data 0x1234 -> mul_instr_o pulses once, dec_ready_o is low for 5 cycles, then wb_rd_o=5, wb_data_o=0x1234.
- Flush mid-DIV: flush_i two cycles after div_instr_o -> no wb_valid_o; a later valid_res_i is ignored; dec_ready_o=1 the next cycle.
- Watchdog: MUL with no valid_res_i -> timeout_o and kill_o pulse at MAX_LAT=80 cycles; state returns to IDLE.
- rd=0 ALU op -> wb_valid_o=1, wb_we_o=0.
- Reset asserted during WAIT_LONG -> all outputs 0 next cycle; a subsequent ALU op completes normally.
